vga_scan_ctrl: RTL

//  Raster scheduler for the VGA output path. Counts pixel and line positions and issues frame-buffer read requests (Rd_en/Addr).

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_scan_ctrl_if.sv | 17 +
 rtl/vga_delay_line.sv | 40 ++++
 rtl/vga_scan_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the VGA scan controller: default 640x480@60
//   timing constants, the {act,hs,vs} sync bundle carried down the fetch
//   delay line, and the 12-bit colour-bar lookup used by the test pattern.
//   No ports (package).
package vga_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int ADDR_W_DEF    = 19;
  localparam int FETCH_LAT_DEF = 2;

  // Timing flags of one pixel slot, all active-high inside the pipeline.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;

  localparam int SYNC_W = 3;

  // Colour-bar table, left to right: white, yellow, cyan, green,
  // magenta, red, blue, black ({R4,G4,B4}).
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      3'd7:    c = 12'h000;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// vga_scan_ctrl_if
//   Frame-buffer read port between the scan controller and the pixel memory.
//   Signals:
//     Rd_en   read strobe, one per active pixel, only meaningful on Pix_ce
//     Addr    linear raster read address (ADDR_W bits)
//     Fb_data 12-bit {R4,G4,B4} pixel, valid FETCH_LAT ce-cycles after Rd_en
//   Modports: master = scan controller, slave = frame-buffer memory.
interface vga_scan_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              Rd_en;
  logic [ADDR_W-1:0] Addr;
  logic [11:0]       Fb_data;

  modport master (output Rd_en, output Addr, input Fb_data);
  modport slave  (input Rd_en, input Addr, output Fb_data);
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   Clock-enable gated shift register of DEPTH stages. Aligns the timing
//   flags (and, with the test pattern, the pixel column) with the data
//   returning from the frame buffer.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset, clears every tap
//     ce    in  shift enable (pixel clock enable)
//     din   in  W-bit value entering stage 0
//     dout  out W-bit value leaving the last stage (registered)
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] taps_r [DEPTH];

  // Shift the taps one place on every enabled pixel slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_r[i] <= {W{1'b0}};
      end
    end else if (ce) begin
      taps_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_r[i] <= taps_r[i-1];
      end
    end
  end

  assign dout = taps_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//   VGA raster scheduler. Counts pixel/line positions, issues linear
//   frame-buffer reads, delays the blank/sync flags by the memory latency
//   and registers the returned pixel so Dout/Nblank/Hsync/Vsync leave
//   together, FETCH_LAT+1 ce-cycles after the matching Rd_en.
//   Optional feature: define VGA_TESTPAT_EN to add the Tp_sel input, which
//   replaces active pixels with eight vertical colour bars and suppresses
//   frame-buffer reads.
//   Ports:
//     clk         in  system clock
//     Nreset      in  asynchronous active-low reset
//     Pix_ce      in  pixel clock enable; all state advances only when 1
//     fb          --  frame-buffer read port (Rd_en, Addr out; Fb_data in)
//     Dout        out pixel to RGB expander, 0 when blanked
//     Nblank      out 1 = visible pixel
//     Hsync       out active-low horizontal sync
//     Vsync       out active-low vertical sync
//     Frame_start out combinational, h=0 && v=0 && Pix_ce
//     Tp_sel      in  (VGA_TESTPAT_EN only) 1 = colour bars replace Fb_data
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FETCH_LAT = FETCH_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   Nreset,
  input  logic                   Pix_ce,
  vga_scan_ctrl_if.master        fb,
  output logic [11:0]            Dout,
  output logic                   Nblank,
  output logic                   Hsync,
  output logic                   Vsync,
  output logic                   Frame_start
`ifdef VGA_TESTPAT_EN
  ,
  input  logic                   Tp_sel
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
`ifdef VGA_TESTPAT_EN
  localparam int DL_W    = SYNC_W + H_W;
`else
  localparam int DL_W    = SYNC_W;
`endif

  // Stage 0: raster counters
  logic [H_W-1:0]    h_cnt_r;
  logic [V_W-1:0]    v_cnt_r;
  logic              act_s;
  logic              hs_s;
  logic              vs_s;
  logic              origin_s;
  logic              tp_sel_s;

  // Stage 1: registered decode and fetch request
  sync_t             sync1_r;
  logic              rd_en_r;
  logic [ADDR_W-1:0] addr_r;

  // Delay-line output and output-register input
  logic [DL_W-1:0]   dl_in_s;
  logic [DL_W-1:0]   dl_out_s;
  sync_t             sync_d_s;
  logic [11:0]       pix_s;

`ifdef VGA_TESTPAT_EN
  logic [H_W-1:0]    col1_r;
  logic [H_W-1:0]    col_d_s;
  logic [2:0]        bar_idx_s;

  assign tp_sel_s  = Tp_sel;
  assign dl_in_s   = {sync1_r, col1_r};
  assign col_d_s   = dl_out_s[H_W-1:0];
  // Column 0..H_ACTIVE-1 maps onto eight equal-width bars.
  assign bar_idx_s = 3'((32'(col_d_s) * 32'd8) / 32'(H_ACTIVE));
`else
  assign tp_sel_s  = 1'b0;
  assign dl_in_s   = sync1_r;
`endif

  assign sync_d_s = dl_out_s[DL_W-1 -: SYNC_W];

  assign act_s    = (h_cnt_r < H_W'(H_ACTIVE)) && (v_cnt_r < V_W'(V_ACTIVE));
  assign hs_s     = (h_cnt_r >= H_W'(H_ACTIVE + H_FP)) &&
                    (h_cnt_r <  H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_s     = (v_cnt_r >= V_W'(V_ACTIVE + V_FP)) &&
                    (v_cnt_r <  V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign origin_s = (h_cnt_r == H_W'(0)) && (v_cnt_r == V_W'(0));

  assign Frame_start = origin_s && Pix_ce;
  assign fb.Rd_en    = rd_en_r;
  assign fb.Addr     = addr_r;

  // Pixel and line counters; the line advances on the same ce as the pixel wrap.
  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      h_cnt_r <= H_W'(0);
      v_cnt_r <= V_W'(0);
    end else if (Pix_ce) begin
      if (h_cnt_r == H_W'(H_TOTAL - 1)) begin
        h_cnt_r <= H_W'(0);
        if (v_cnt_r == V_W'(V_TOTAL - 1)) begin
          v_cnt_r <= V_W'(0);
        end else begin
          v_cnt_r <= v_cnt_r + V_W'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + H_W'(1);
      end
    end
  end

  // Stage-1 decode, read strobe and read address.
  // Addr steps after every active slot already in stage 1, and is forced to 0
  // when the slot entering stage 1 is the frame origin, so it never drifts.
  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      sync1_r <= '{act: 1'b0, hs: 1'b0, vs: 1'b0};
      rd_en_r <= 1'b0;
      addr_r  <= ADDR_W'(0);
`ifdef VGA_TESTPAT_EN
      col1_r  <= H_W'(0);
`endif
    end else if (Pix_ce) begin
      sync1_r <= '{act: act_s, hs: hs_s, vs: vs_s};
      rd_en_r <= act_s && !tp_sel_s;
`ifdef VGA_TESTPAT_EN
      col1_r  <= h_cnt_r;
`endif
      if (origin_s) begin
        addr_r <= ADDR_W'(0);
      end else if (sync1_r.act) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
    end
  end

  vga_delay_line #(
    .DEPTH (FETCH_LAT),
    .W     (DL_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (Nreset),
    .ce    (Pix_ce),
    .din   (dl_in_s),
    .dout  (dl_out_s)
  );

  // Select the pixel for the output register: memory data, bar, or black.
  always_comb begin
    pix_s = 12'h000;
    if (sync_d_s.act) begin
`ifdef VGA_TESTPAT_EN
      if (tp_sel_s) begin
        pix_s = bar_colour(bar_idx_s);
      end else begin
        pix_s = fb.Fb_data;
      end
`else
      pix_s = fb.Fb_data;
`endif
    end else begin
      pix_s = 12'h000;
    end
  end

  // Output register: pixel, blank and active-low syncs leave on the same ce.
  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      Dout   <= 12'h000;
      Nblank <= 1'b0;
      Hsync  <= 1'b1;
      Vsync  <= 1'b1;
    end else if (Pix_ce) begin
      Dout   <= pix_s;
      Nblank <= sync_d_s.act;
      Hsync  <= !sync_d_s.hs;
      Vsync  <= !sync_d_s.vs;
    end
  end

endmodule
